// File: rtl/dpi_char_stream_driver_pkg.sv
// Shared widths and FSM encoding for the regex-matcher character stream driver.
package dpi_char_stream_driver_pkg;
  localparam int STREAM_ID_W = 6;
  localparam int CHAR_W      = 8;
  localparam int NUM_STREAMS = 64;
  localparam int CNT_W       = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_GAP    = 3'd2,
    ST_STREAM = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_EOP    = 3'd5
  } state_t;
endpackage

// File: rtl/dpi_stream_seen_table.sv
// Bitmap of stream IDs that have completed a packet since the last clear.
// A mark in the same cycle as a clear leaves that one ID set.
module dpi_stream_seen_table
  import dpi_char_stream_driver_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   mark,
  input  logic [STREAM_ID_W-1:0] mark_id,
  input  logic [STREAM_ID_W-1:0] lookup_id,
  output logic                   seen
);
  logic [NUM_STREAMS-1:0] bits_q;
  logic [NUM_STREAMS-1:0] bits_nxt;

  always_comb begin
    bits_nxt = clear ? '0 : bits_q;
    if (mark) bits_nxt[mark_id] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bits_q <= '0;
    else        bits_q <= bits_nxt;
  end

  assign seen = bits_q[lookup_id];
endmodule

// File: rtl/dpi_char_stream_driver.sv
// Converts ingress packet beats into the load_state / char_in / eop sequence
// consumed by every regex wrapper, tracking per-stream first use.
module dpi_char_stream_driver
  import dpi_char_stream_driver_pkg::*;
#(
  parameter int LOAD_GAP = 2,
  parameter int EOP_GAP  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   dpi_en,
  input  logic                   clear_seen,
  input  logic [NUM_STREAMS-1:0] enable_mask,
  input  logic [CHAR_W-1:0]      pkt_data,
  input  logic                   pkt_vld,
  input  logic                   pkt_sop,
  input  logic                   pkt_eop,
  input  logic [STREAM_ID_W-1:0] pkt_stream_id,
  output logic                   pkt_rdy,
  output logic                   load_state,
  output logic [STREAM_ID_W-1:0] stream_id,
  output logic                   new_stream_id,
  output logic                   enable,
  output logic [CHAR_W-1:0]      char_in,
  output logic                   char_in_vld,
  output logic                   eop,
  output logic [CNT_W-1:0]       pkt_count,
  output logic [CNT_W-1:0]       byte_count,
  output logic                   err_sop,
  output state_t                 dbg_state
);
  // Ingress handshake: a beat transfers on a rising edge where pkt_vld and
  // pkt_rdy are both high; pkt_rdy may depend combinationally on pkt_vld/pkt_sop.
  state_t     state, state_nxt;
  logic       first_beat;
  logic [7:0] wait_cnt;
  logic [7:0] gap_cnt;
  logic [7:0] since;
  logic       seen_hit;
  logic       start;
  logic       sop_err;
  logic       accept;

  assign start      = dpi_en & pkt_vld & pkt_sop;
  assign sop_err    = (state == ST_STREAM) & pkt_vld & pkt_sop & ~first_beat;
  assign accept     = (state == ST_STREAM) & pkt_vld & pkt_rdy;
  // Cycles since the most recent char_in_vld, counting the current cycle as 0.
  assign since      = char_in_vld ? 8'd0 : gap_cnt;
  assign load_state = (state == ST_LOAD);
  assign eop        = (state == ST_EOP);
  assign dbg_state  = state;

  always_comb begin
    state_nxt = state;
    pkt_rdy   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start)                    state_nxt = ST_LOAD;
        else if (pkt_vld && !pkt_sop) pkt_rdy   = 1'b1;
      end
      // The STREAM state accepts a beat one cycle before it shows on char_in,
      // so the gap states cover LOAD_GAP-1 cycles including LOAD itself.
      ST_LOAD:   state_nxt = (LOAD_GAP > 2) ? ST_GAP : ST_STREAM;
      ST_GAP:    if (int'(wait_cnt) >= LOAD_GAP - 3) state_nxt = ST_STREAM;
      ST_STREAM: begin
        if (sop_err) begin
          state_nxt = ST_DRAIN;
        end else begin
          pkt_rdy = 1'b1;
          if (pkt_vld && pkt_eop) state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN:  if (int'(since) >= EOP_GAP - 1) state_nxt = ST_EOP;
      ST_EOP:    state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      stream_id     <= '0;
      enable        <= 1'b0;
      new_stream_id <= 1'b0;
      first_beat    <= 1'b0;
      wait_cnt      <= '0;
      gap_cnt       <= '0;
      char_in       <= '0;
      char_in_vld   <= 1'b0;
      pkt_count     <= '0;
      byte_count    <= '0;
      err_sop       <= 1'b0;
    end else begin
      state <= state_nxt;
      if ((state == ST_IDLE) && start) begin
        stream_id     <= pkt_stream_id;
        enable        <= enable_mask[pkt_stream_id];
        new_stream_id <= ~seen_hit;
      end
      if (state == ST_LOAD) first_beat <= 1'b1;
      else if (accept)      first_beat <= 1'b0;
      wait_cnt    <= (state == ST_GAP) ? wait_cnt + 8'd1 : 8'd0;
      gap_cnt     <= (since == 8'hFF) ? since : since + 8'd1;
      char_in_vld <= accept;
      if (accept) begin
        char_in    <= pkt_data;
        byte_count <= byte_count + 32'd1;
      end
      if (state == ST_EOP) pkt_count <= pkt_count + 32'd1;
      if (sop_err)         err_sop   <= 1'b1;
    end
  end

  dpi_stream_seen_table u_seen (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear_seen),
    .mark      (state == ST_EOP),
    .mark_id   (stream_id),
    .lookup_id (pkt_stream_id),
    .seen      (seen_hit)
  );
endmodule
